store_buffer_fwd: RTL

Parametrised, forwarding-capable successor to the current store buffer. It sits between the LSU/MMU and the dcache.
- Stores are held in a BLEN-deep circular FIFO.
- A store to the same word as the youngest idle entry is coalesced into that entry.
- Entries drain to the dcache in order over a req/ack handshake.
- Loads get combinational byte-granular store-to-load forwarding from all valid entries.

---
 rtl/store_buffer_fwd_if.sv | 48 ++++
 rtl/store_buffer_fwd.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/store_buffer_fwd_if.sv
// Bundles the LSU/MMU-facing and dcache-facing signals of the store buffer.
// slave is the buffer's side and master is the side that drives requests and acks.
interface store_buffer_fwd_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_SEL_WIDTH = 4,
  parameter int CNT_WIDTH      = 3
);
  logic                      lsummu2stb_req;
  logic                      lsummu2stb_w_en;
  logic [ADDR_WIDTH-1:0]     lsummu2stb_addr;
  logic [DATA_WIDTH-1:0]     lsummu2stb_wdata;
  logic [BYTE_SEL_WIDTH-1:0] lsummu2stb_sel_byte;
  logic                      stb2lsummu_ack;
  logic                      stb2lsummu_stall;
  logic [ADDR_WIDTH-1:0]     lsummu2stb_ld_addr;
  logic [BYTE_SEL_WIDTH-1:0] lsummu2stb_ld_sel;
  logic [BYTE_SEL_WIDTH-1:0] stb2lsummu_fwd_sel;
  logic [DATA_WIDTH-1:0]     stb2lsummu_fwd_data;
  logic                      stb2lsummu_fwd_hit;
  logic                      stb2dcache_req;
  logic                      stb2dcache_w_en;
  logic [ADDR_WIDTH-1:0]     stb2dcache_addr;
  logic [DATA_WIDTH-1:0]     stb2dcache_wdata;
  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte;
  logic                      dcache2stb_ack;
  logic                      stb2dcache_empty;
  logic [CNT_WIDTH-1:0]      stb_count;
  logic                      stb_dbg_drain_busy;

  modport slave (
    input  lsummu2stb_req, lsummu2stb_w_en, lsummu2stb_addr, lsummu2stb_wdata,
           lsummu2stb_sel_byte, lsummu2stb_ld_addr, lsummu2stb_ld_sel, dcache2stb_ack,
    output stb2lsummu_ack, stb2lsummu_stall, stb2lsummu_fwd_sel, stb2lsummu_fwd_data,
           stb2lsummu_fwd_hit, stb2dcache_req, stb2dcache_w_en, stb2dcache_addr,
           stb2dcache_wdata, stb2dcache_sel_byte, stb2dcache_empty, stb_count,
           stb_dbg_drain_busy
  );

  modport master (
    output lsummu2stb_req, lsummu2stb_w_en, lsummu2stb_addr, lsummu2stb_wdata,
           lsummu2stb_sel_byte, lsummu2stb_ld_addr, lsummu2stb_ld_sel, dcache2stb_ack,
    input  stb2lsummu_ack, stb2lsummu_stall, stb2lsummu_fwd_sel, stb2lsummu_fwd_data,
           stb2lsummu_fwd_hit, stb2dcache_req, stb2dcache_w_en, stb2dcache_addr,
           stb2dcache_wdata, stb2dcache_sel_byte, stb2dcache_empty, stb_count,
           stb_dbg_drain_busy
  );
endinterface

// File: rtl/store_buffer_fwd.sv
// In-order coalescing store buffer that drains to the dcache and forwards bytes to loads.
// Handshake: a store is taken when req&w_en and no stall; the dcache write is held until ack.
module store_buffer_fwd #(
  parameter int BLEN           = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_SEL_WIDTH = 4,
  parameter bit COALESCE_EN    = 1'b1
) (
  input logic clk,
  input logic rst_n,
  store_buffer_fwd_if.slave bus
);
  localparam int PW  = $clog2(BLEN);
  localparam int CW  = PW + 1;
  localparam int OFF = $clog2(BYTE_SEL_WIDTH);

  typedef enum logic {IDLE, REQ} state_t;

  logic [ADDR_WIDTH-1:0]     addr_q [BLEN];
  logic [DATA_WIDTH-1:0]     data_q [BLEN];
  logic [BYTE_SEL_WIDTH-1:0] mask_q [BLEN];
  logic [PW-1:0]             head_q, tail_q;
  logic [CW-1:0]             count_q;
  state_t                    state_q, state_d;
  logic                      req_q, req_d, ack_q;
  logic [ADDR_WIDTH-1:0]     oaddr_q, oaddr_d;
  logic [DATA_WIDTH-1:0]     odata_q, odata_d;
  logic [BYTE_SEL_WIDTH-1:0] osel_q, osel_d;

  logic                      st, coal, enq, pop, full, coal_head;
  logic [PW-1:0]             youngest, fidx;
  logic [DATA_WIDTH-1:0]     wmask, merged, fwd_data;
  logic [BYTE_SEL_WIDTH-1:0] fwd_sel;

  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [BYTE_SEL_WIDTH-1:0] sel);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int b = 0; b < BYTE_SEL_WIDTH; b++) m[8*b +: 8] = {8{sel[b]}};
    return m;
  endfunction

  always_comb begin
    st        = bus.lsummu2stb_req & bus.lsummu2stb_w_en;
    youngest  = tail_q - PW'(1);
    full      = (count_q == CW'(BLEN));
    coal      = COALESCE_EN && st && (count_q != '0) &&
                (addr_q[youngest][ADDR_WIDTH-1:OFF] == bus.lsummu2stb_addr[ADDR_WIDTH-1:OFF]) &&
                !((youngest == head_q) && (state_q == REQ));
    enq       = st && !coal && !full;
    pop       = (state_q == REQ) && bus.dcache2stb_ack;
    wmask     = lane_mask(bus.lsummu2stb_sel_byte);
    merged    = (data_q[youngest] & ~wmask) | (bus.lsummu2stb_wdata & wmask);
    coal_head = coal && (youngest == head_q);
  end

  // Drain FSM; a store merging into the head as it is captured is folded into the captured copy.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    oaddr_d = oaddr_q;
    odata_d = odata_q;
    osel_d  = osel_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = REQ;
          req_d   = 1'b1;
          oaddr_d = addr_q[head_q];
          odata_d = coal_head ? merged : data_q[head_q];
          osel_d  = coal_head ? (mask_q[head_q] | bus.lsummu2stb_sel_byte) : mask_q[head_q];
        end
      end
      REQ: begin
        if (bus.dcache2stb_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Oldest-to-youngest sweep so the youngest matching entry wins each lane.
  always_comb begin
    fwd_sel  = '0;
    fwd_data = '0;
    fidx     = head_q;
    for (int i = 0; i < BLEN; i++) begin
      fidx = head_q + PW'(i);
      if ((CW'(i) < count_q) &&
          (addr_q[fidx][ADDR_WIDTH-1:OFF] == bus.lsummu2stb_ld_addr[ADDR_WIDTH-1:OFF])) begin
        for (int b = 0; b < BYTE_SEL_WIDTH; b++) begin
          if (mask_q[fidx][b]) begin
            fwd_sel[b]          = 1'b1;
            fwd_data[8*b +: 8]  = data_q[fidx][8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLEN; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      oaddr_q <= '0;
      odata_q <= '0;
      osel_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      oaddr_q <= oaddr_d;
      odata_q <= odata_d;
      osel_q  <= osel_d;
      ack_q   <= coal | enq;
      if (pop) begin
        mask_q[head_q] <= '0;
        head_q         <= head_q + PW'(1);
      end
      if (coal) begin
        mask_q[youngest] <= mask_q[youngest] | bus.lsummu2stb_sel_byte;
        data_q[youngest] <= merged;
      end
      if (enq) begin
        addr_q[tail_q] <= bus.lsummu2stb_addr;
        data_q[tail_q] <= bus.lsummu2stb_wdata;
        mask_q[tail_q] <= bus.lsummu2stb_sel_byte;
        tail_q         <= tail_q + PW'(1);
      end
      if (enq && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !enq) count_q <= count_q - CW'(1);
    end
  end

  assign bus.stb2lsummu_stall    = st & ~coal & full;
  assign bus.stb2lsummu_ack      = ack_q;
  assign bus.stb2lsummu_fwd_sel  = fwd_sel;
  assign bus.stb2lsummu_fwd_data = fwd_data;
  assign bus.stb2lsummu_fwd_hit  = (bus.lsummu2stb_ld_sel != '0) &&
                                   ((fwd_sel & bus.lsummu2stb_ld_sel) == bus.lsummu2stb_ld_sel);
  assign bus.stb2dcache_req      = req_q;
  assign bus.stb2dcache_w_en     = req_q;
  assign bus.stb2dcache_addr     = oaddr_q;
  assign bus.stb2dcache_wdata    = odata_q;
  assign bus.stb2dcache_sel_byte = osel_q;
  assign bus.stb2dcache_empty    = (count_q == '0);
  assign bus.stb_count           = count_q;
  assign bus.stb_dbg_drain_busy  = (state_q == REQ);
endmodule
